// File: rtl/battle_anim_pkg.sv
// Shared types and screen constants for the battle sprite animators.
package battle_anim_pkg;

  typedef enum logic [2:0] {
    HIDDEN,
    ENTER,
    IDLE,
    HIT,
    FAINT,
    FAINTED
  } anim_state_t;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

endpackage

// File: rtl/frame_tick_gen.sv
// Registered one-cycle frame tick at the first vertical blanking line.
// Shared by the back- and front-sprite animators.
module frame_tick_gen
  import battle_anim_pkg::*;
#(
  parameter int FRAME_LINE = V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        tick
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= (hcount == 11'd0) && (vcount == 10'(FRAME_LINE));
    end
  end

endmodule

// File: rtl/battle_sprite_animator.sv
// Back-sprite position/visibility animator: slide-in, idle bob, hit flash, faint.
// Define ANIM_BOB_EN to build the idle bob counter.
module battle_sprite_animator
  import battle_anim_pkg::*;
#(
  parameter int START_X      = 0,
  parameter int HOME_X       = 128,
  parameter int HOME_Y       = 400,
  parameter int HEIGHT       = 144,
  parameter int SLIDE_STEP   = 4,
  parameter int FAINT_STEP   = 4,
  parameter int BOB_AMPL     = 2,
  parameter int BOB_PERIOD   = 16,
  parameter int FLASH_FRAMES = 4,
  parameter int FLASH_COUNT  = 3,
  parameter int FRAME_LINE   = 768
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        enter_in,
  input  logic        hit_in,
  input  logic        faint_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        visible_out,
  output logic        busy_out,
  output logic        done_out
);

  if (HOME_X > 2047) begin : g_bad_home_x
    $error("HOME_X must not exceed 2047");
  end
  if (HOME_Y + HEIGHT > 1023) begin : g_bad_faint_end
    $error("HOME_Y+HEIGHT must not exceed 1023");
  end
  if (HOME_Y + BOB_AMPL > 1023) begin : g_bad_bob_ampl
    $error("HOME_Y+BOB_AMPL must not exceed 1023");
  end
  if ((BOB_PERIOD < 2) || ((BOB_PERIOD % 2) != 0)) begin : g_bad_bob_period
    $error("BOB_PERIOD must be even and at least 2");
  end

  localparam int FF_W = $clog2(FLASH_FRAMES + 1);
  localparam int TG_W = $clog2(2 * FLASH_COUNT + 1);

  localparam logic [10:0]     START_X_C  = 11'(START_X);
  localparam logic [10:0]     HOME_X_C   = 11'(HOME_X);
  localparam logic [11:0]     HOME_X_W   = 12'(HOME_X);
  localparam logic [9:0]      HOME_Y_C   = 10'(HOME_Y);
  localparam logic [9:0]      Y_END_C    = 10'(HOME_Y + HEIGHT);
  localparam logic [10:0]     Y_END_W    = 11'(HOME_Y + HEIGHT);
  localparam logic [FF_W-1:0] FF_LAST    = FF_W'(FLASH_FRAMES - 1);
  localparam logic [TG_W-1:0] TG_LAST    = TG_W'(2 * FLASH_COUNT - 1);

  anim_state_t     state;
  logic            tick;
  logic [FF_W-1:0] flash_frame;
  logic [TG_W-1:0] flash_toggle;
  logic [11:0]     x_sum;
  logic [10:0]     y_sum;

`ifdef ANIM_BOB_EN
  localparam int BOB_W = $clog2(BOB_PERIOD);
  localparam logic [BOB_W-1:0] BOB_LAST      = BOB_W'(BOB_PERIOD - 1);
  localparam logic [BOB_W-1:0] BOB_HIGH_FROM = BOB_W'(BOB_PERIOD / 2 - 1);
  localparam logic [9:0]       HOME_Y_BOB    = 10'(HOME_Y + BOB_AMPL);
  logic [BOB_W-1:0] bob_cnt;
`endif

  frame_tick_gen #(
    .FRAME_LINE (FRAME_LINE)
  ) u_tick (
    .clk    (pixel_clk_in),
    .rst    (rst_in),
    .hcount (hcount_in),
    .vcount (vcount_in),
    .tick   (tick)
  );

  // One extra bit so a step past the clamp point cannot wrap.
  assign x_sum = {1'b0, x_out} + 12'(SLIDE_STEP);
  assign y_sum = {1'b0, y_out} + 11'(FAINT_STEP);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state        <= HIDDEN;
      x_out        <= START_X_C;
      y_out        <= HOME_Y_C;
      visible_out  <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      flash_frame  <= '0;
      flash_toggle <= '0;
`ifdef ANIM_BOB_EN
      bob_cnt      <= '0;
`endif
    end else begin
      done_out <= 1'b0;
`ifdef ANIM_BOB_EN
      // Held at zero outside IDLE so every IDLE entry starts a fresh bob cycle.
      if (state != IDLE) bob_cnt <= '0;
`endif
      case (state)
        HIDDEN, FAINTED: begin
          if (enter_in) begin
            state       <= ENTER;
            x_out       <= START_X_C;
            y_out       <= HOME_Y_C;
            visible_out <= 1'b1;
            busy_out    <= 1'b1;
          end
        end
        ENTER: begin
          if (tick) begin
            if (x_sum >= HOME_X_W) begin
              x_out    <= HOME_X_C;
              state    <= IDLE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
            end else begin
              x_out <= x_sum[10:0];
            end
          end
        end
        IDLE: begin
          if (faint_in) begin
            state       <= FAINT;
            y_out       <= HOME_Y_C;
            visible_out <= 1'b1;
            busy_out    <= 1'b1;
          end else if (hit_in) begin
            state        <= HIT;
            y_out        <= HOME_Y_C;
            visible_out  <= 1'b0;
            busy_out     <= 1'b1;
            flash_frame  <= '0;
            flash_toggle <= '0;
          end
`ifdef ANIM_BOB_EN
          else if (tick) begin
            if (bob_cnt == BOB_LAST) begin
              bob_cnt <= '0;
              y_out   <= HOME_Y_C;
            end else begin
              bob_cnt <= bob_cnt + 1'b1;
              y_out   <= (bob_cnt >= BOB_HIGH_FROM) ? HOME_Y_BOB : HOME_Y_C;
            end
          end
`endif
        end
        HIT: begin
          if (faint_in) begin
            state       <= FAINT;
            y_out       <= HOME_Y_C;
            visible_out <= 1'b1;
          end else if (tick) begin
            if (flash_frame == FF_LAST) begin
              flash_frame <= '0;
              // The last half-period ends the flash with the sprite shown.
              if (flash_toggle == TG_LAST) begin
                state       <= IDLE;
                visible_out <= 1'b1;
                busy_out    <= 1'b0;
              end else begin
                flash_toggle <= flash_toggle + 1'b1;
                visible_out  <= ~visible_out;
              end
            end else begin
              flash_frame <= flash_frame + 1'b1;
            end
          end
        end
        FAINT: begin
          if (tick) begin
            if (y_sum >= Y_END_W) begin
              y_out       <= Y_END_C;
              state       <= FAINTED;
              visible_out <= 1'b0;
              busy_out    <= 1'b0;
              done_out    <= 1'b1;
            end else begin
              y_out <= y_sum[9:0];
            end
          end
        end
        default: state <= HIDDEN;
      endcase
    end
  end

endmodule

// File: tb/tb_battle_sprite_animator.sv
// Directed self-checking bench for battle_sprite_animator (frame ticks driven directly).
module tb_battle_sprite_animator;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in       = 1'b1;
  logic [10:0] hcount_in    = 11'd5;
  logic [9:0]  vcount_in    = 10'd0;
  logic        enter_in     = 1'b0;
  logic        hit_in       = 1'b0;
  logic        faint_in     = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        visible_out;
  logic        busy_out;
  logic        done_out;

  int vectors     = 0;
  int miscompares = 0;

  battle_sprite_animator dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .enter_in     (enter_in),
    .hit_in       (hit_in),
    .faint_in     (faint_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .visible_out  (visible_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  task automatic step();
    @(posedge pixel_clk_in);
    #1;
  endtask

  // Present the tick condition for one cycle, then let the animator consume the tick.
  task automatic frame_tick();
    hcount_in = 11'd0;
    vcount_in = 10'd768;
    step();
    hcount_in = 11'd5;
    vcount_in = 10'd0;
    step();
  endtask

  task automatic apply_stimulus(input logic enter, input logic hit, input logic faint);
    enter_in = enter;
    hit_in   = hit;
    faint_in = faint;
    step();
    enter_in = 1'b0;
    hit_in   = 1'b0;
    faint_in = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_hidden(input string tag);
    check_output({tag, "_x"}, 16'(x_out), 16'd0);
    check_output({tag, "_y"}, 16'(y_out), 16'd400);
    check_output({tag, "_vis"}, 16'(visible_out), 16'd0);
    check_output({tag, "_busy"}, 16'(busy_out), 16'd0);
  endtask

  // Full slide-in from x=0: x=4k after tick k, done only on tick 32.
  task automatic run_slide(input string tag);
    for (int k = 1; k <= 32; k++) begin
      frame_tick();
      check_output({tag, "_x"}, 16'(x_out), 16'((k * 4 > 128) ? 128 : k * 4));
      check_output({tag, "_done"}, 16'(done_out), 16'(k == 32));
      check_output({tag, "_busy"}, 16'(busy_out), 16'(k != 32));
    end
    step();
    check_output({tag, "_done_clear"}, 16'(done_out), 16'd0);
  endtask

  initial begin
    $display("[TB] start");
    step();
    step();
    check_hidden("reset");
    check_output("reset_done", 16'(done_out), 16'd0);
    rst_in = 1'b0;

    apply_stimulus(1'b0, 1'b1, 1'b0);
    frame_tick();
    check_hidden("hit_hidden");

    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("enter_x", 16'(x_out), 16'd0);
    check_output("enter_vis", 16'(visible_out), 16'd1);
    check_output("enter_busy", 16'(busy_out), 16'd1);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_output("enter_ignore_busy", 16'(busy_out), 16'd1);
    check_output("enter_ignore_vis", 16'(visible_out), 16'd1);
    run_slide("slide");

    for (int k = 1; k <= 32; k++) begin
      frame_tick();
`ifdef ANIM_BOB_EN
      check_output("bob_y", 16'(y_out), 16'(((k % 16) < 8) ? 400 : 402));
`else
      check_output("idle_y", 16'(y_out), 16'd400);
`endif
      check_output("idle_x", 16'(x_out), 16'd128);
      check_output("idle_vis", 16'(visible_out), 16'd1);
    end

    // Park the bob in its low phase so the flash must restore HOME_Y.
    for (int k = 0; k < 9; k++) frame_tick();
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("hit_vis0", 16'(visible_out), 16'd0);
    check_output("hit_busy", 16'(busy_out), 16'd1);
    check_output("hit_y", 16'(y_out), 16'd400);
    for (int k = 1; k <= 24; k++) begin
      frame_tick();
      if (k == 10) apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("flash_vis", 16'(visible_out), 16'((k == 24) ? 1 : ((k / 4) % 2)));
      check_output("flash_busy", 16'(busy_out), 16'(k != 24));
    end
    frame_tick();
    check_output("post_flash_busy", 16'(busy_out), 16'd0);
    check_output("post_flash_vis", 16'(visible_out), 16'd1);

    for (int k = 0; k < 3; k++) frame_tick();
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_output("faint_busy", 16'(busy_out), 16'd1);
    check_output("faint_y0", 16'(y_out), 16'd400);
    for (int k = 1; k <= 36; k++) begin
      frame_tick();
      if (k == 5) apply_stimulus(1'b1, 1'b1, 1'b1);
      check_output("faint_y", 16'(y_out), 16'(400 + 4 * k));
      check_output("faint_vis", 16'(visible_out), 16'(k != 36));
      check_output("faint_done", 16'(done_out), 16'(k == 36));
    end
    step();
    check_output("faint_done_clear", 16'(done_out), 16'd0);

    apply_stimulus(1'b0, 1'b1, 1'b1);
    frame_tick();
    check_output("fainted_y", 16'(y_out), 16'd544);
    check_output("fainted_vis", 16'(visible_out), 16'd0);
    check_output("fainted_busy", 16'(busy_out), 16'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("replay_x", 16'(x_out), 16'd0);
    check_output("replay_y", 16'(y_out), 16'd400);
    check_output("replay_vis", 16'(visible_out), 16'd1);
    run_slide("replay");

    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) frame_tick();
    check_output("abort_pre_x", 16'(x_out), 16'd40);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_hidden("abort");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("restart_vis", 16'(visible_out), 16'd1);
    run_slide("restart");

    apply_stimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) frame_tick();
    check_output("abort_flash_vis0", 16'(visible_out), 16'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("abort_flash_vis", 16'(visible_out), 16'd1);
    check_output("abort_flash_busy", 16'(busy_out), 16'd1);
    frame_tick();
    check_output("abort_flash_y", 16'(y_out), 16'd404);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
